// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter through its START/BUSY handshake.
// The controller pushes at clk rate, and the FSM drains one byte per UART frame.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned BUSY_WAIT_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy_timeout,
  input  logic                  clr_flags,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [WIDTH-1:0]      tx_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned TW    = $clog2(BUSY_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [TW-1:0]    wait_cnt_q;
  logic [TW-1:0]    wait_cnt_d;
  logic [TW-1:0]    wait_inc;
  logic             wait_hit;

  logic             do_push;
  logic             do_pop;
  logic             ovf_evt;
  logic             to_evt;
  logic             tx_start_d;
  logic [CW-1:0]    count_d;

  // A push is judged against the registered full flag, so a pop at the same edge cannot make room.
  assign do_push  = wr_en & ~full;
  assign ovf_evt  = wr_en & full;
  assign wait_inc = wait_cnt_q + TW'(1);
  assign wait_hit = (wait_inc == TW'(BUSY_WAIT_MAX));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      overflow     <= 1'b0;
      busy_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      tx_start     <= tx_start_d;
      count        <= count_d;
      full         <= (count_d == CW'(DEPTH));
      empty        <= (count_d == CW'(0));
      overflow     <= ovf_evt | (overflow & ~clr_flags);
      busy_timeout <= to_evt  | (busy_timeout & ~clr_flags);
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          state_d = STROBE;
        end
      end
      STROBE: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (wait_hit) begin
          state_d = IDLE;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath control
  always_comb begin
    do_pop     = 1'b0;
    tx_start_d = 1'b0;
    to_evt     = 1'b0;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        do_pop     = (state_d == STROBE);
        tx_start_d = (state_d == STROBE);
      end
      STROBE: begin
        wait_cnt_d = '0;
      end
      WAIT_HI: begin
        if (!tx_busy) begin
          wait_cnt_d = wait_inc;
          to_evt     = wait_hit;
        end
      end
      default: begin
        wait_cnt_d = wait_cnt_q;
      end
    endcase
    count_d = count + CW'(do_push) - CW'(do_pop);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based transaction model
// plus a small UART responder that can answer normally, never, or stay busy.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned BWM        = 8;
  localparam int unsigned DEPTH      = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             clr_flags = 1'b0;
  logic             tx_busy = 1'b0;
  logic             full, empty, overflow, busy_timeout, tx_start;
  logic [DEPTH_LOG2:0] count;
  logic [WIDTH-1:0] tx_data;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH), .BUSY_WAIT_MAX(BWM)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy_timeout(busy_timeout), .clr_flags(clr_flags), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued bytes, sticky flags, last byte handed out, handshake progress
  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_to = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  bit               hs_active = 1'b0;
  bit               hs_seen_busy = 1'b0;
  int               hs_edges = 0;

  // UART responder: 0 = busy for uhold cycles starting one cycle after start, 1 = never busy, 2 = always busy
  int               umode = 0;
  int               uhold = 20;
  int               bcnt = 0;
  bit               rise_pend = 1'b0;

  task automatic cycle(input bit wr, input logic [WIDTH-1:0] d, input bit clr, input bit rst);
    int pre;
    bit busy_b;
    bit exp_pop;
    bit ovf_evt;
    bit to_evt;
    wr_en     = wr;
    wr_data   = d;
    clr_flags = clr;
    reset_n   = !rst;
    pre       = q.size();
    busy_b    = tx_busy;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0; m_to = 1'b0; m_data = '0;
      hs_active = 1'b0; hs_seen_busy = 1'b0; hs_edges = 0;
      bcnt = 0; rise_pend = 1'b0;
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy_timeout", 32'(busy_timeout), 32'd0);
    end else begin
      to_evt = 1'b0;
      // A byte goes out only when the previous frame is finished, data waits and the UART is idle
      exp_pop = !hs_active && (pre > 0) && !busy_b;
      ovf_evt = wr && (pre == DEPTH);
      if (hs_active) begin
        hs_edges++;
        if (!hs_seen_busy) begin
          if (hs_edges >= 2 && busy_b) hs_seen_busy = 1'b1;
          else if (hs_edges == BWM + 1) begin
            to_evt = 1'b1;
            hs_active = 1'b0;
          end
        end else if (!busy_b) begin
          hs_active = 1'b0;
        end
      end
      check("tx_start", 32'(tx_start), 32'(exp_pop));
      if (exp_pop) begin
        m_data = q.pop_front();
        hs_active = 1'b1; hs_seen_busy = 1'b0; hs_edges = 0;
      end
      if (wr && pre < DEPTH) q.push_back(d);
      m_ovf = ovf_evt | (m_ovf & !clr);
      m_to  = to_evt  | (m_to  & !clr);
      check("tx_data", 32'(tx_data), 32'(m_data));
      check("count", 32'(count), 32'(q.size()));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("busy_timeout", 32'(busy_timeout), 32'(m_to));
    end
    case (umode)
      2: tx_busy = 1'b1;
      1: tx_busy = 1'b0;
      default: begin
        if (rise_pend) begin
          bcnt = uhold;
          rise_pend = 1'b0;
        end
        if (tx_start && !rst) rise_pend = 1'b1;
        tx_busy = (bcnt > 0);
        if (bcnt > 0) bcnt--;
      end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || hs_active) && n < 3000) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    check("drain_done", 32'(q.size() == 0 && !hs_active), 32'd1);
  endtask

  initial begin
    int n;
    // Reset values
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // Single byte into an empty FIFO
    umode = 0; uhold = 20;
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("a5_strobe", 32'(tx_start), 32'd1);
    check("a5_data", 32'(tx_data), 32'hA5);
    drain();
    idle(3);

    // Burst of 16 bytes
    for (int i = 0; i < 16; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    drain();

    // Overflow while the UART stays busy, then clear it
    umode = 2;
    idle(2);
    for (int i = 16; i <= 32; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("ovf_cleared", 32'(overflow), 32'd0);
    umode = 0; uhold = 2;
    drain();

    // Concurrent push and drain, wrapping the pointers several times
    uhold = 3;
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(0, 5) < 2), WIDTH'($urandom), 1'b0, 1'b0);
    drain();

    // UART that never answers
    umode = 1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    idle(BWM + 1);
    check("timeout_flag", 32'(busy_timeout), 32'd1);
    drain();
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("timeout_cleared", 32'(busy_timeout), 32'd0);
    umode = 0;
    idle(2);

    // Reset in the middle of a frame with bytes still queued
    uhold = 20;
    for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(8'h50 + i), 1'b0, 1'b0);
    n = 0;
    while (!(hs_active && hs_seen_busy) && n < 100) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    check("reached_wait_lo", 32'(hs_active && hs_seen_busy), 32'd1);
    check("queued_before_rst", 32'(count), 32'd3);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(30);

    // Random soak across UART behaviours
    for (int blk = 0; blk < 12; blk++) begin
      n = $urandom_range(0, 9);
      umode = (n < 6) ? 0 : ((n < 8) ? 1 : 2);
      uhold = $urandom_range(1, 6);
      for (int i = 0; i < 50; i++)
        cycle($urandom_range(0, 1) == 1, WIDTH'($urandom), $urandom_range(0, 19) == 0, 1'b0);
    end
    umode = 0;
    drain();
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
